revelar_casillas: RTL and testbench
===================================

Name: revelar_casillas

Overview:
- Player-side reader of the finished Minesweeper board: consumes the 8x8 matrix of 9-bit cells produced by the board generator (bomb flag plus adjacent-bomb count).
- Executes reveal and flag commands at a cursor position and maintains revealed/flagged masks for the display.
- Performs iterative flood-fill of zero-count regions using an index stack.
- Reports loss on a bomb hit and win when every non-bomb cell is revealed.

Parameters:
- N, 8, board side length; cell count N*N = 64, index width 6.
- PILA_DEPTH, 64, flood-fill stack depth; must be >= N*N.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- matrizEntrada  input  9 x [8][8]  board; cell[8] = bomb, cell[3:0] = adjacent count 0..8, cell[7:4] ignored; held stable between start_game pulses
- start_game  input  1  pulse; clears masks and latches bomb total
- fila  input  3  cursor row
- columna  input  3  cursor column
- reveal_req  input  1  reveal request at cursor
- flag_req  input  1  toggle flag at cursor
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse at end of each reveal command
- revelada  output  64  revealed mask, bit index = fila*8+columna
- bandera  output  64  flag mask, same indexing
- perdio  output  1  sticky loss
- gano  output  1  sticky win
- reveladas_cnt  output  7  number of revealed cells

Behaviour:
- Reset values: all outputs 0, state IDLE, stack empty, latched bomb total 0. A mid-flood reset aborts immediately with the same values.
- Game active means perdio=0 and gano=0. While not active, reveal_req and flag_req are ignored; only start_game acts.
- start_game in IDLE (priority over reveal_req and flag_req):
  - clears revelada, bandera, perdio, gano and reveladas_cnt next cycle;
  - latches bomb total = popcount of cell[8] over all 64 cells (7 bits).
- start_game while busy is ignored.
- flag_req in IDLE, game active, reveal_req low:
  - toggles bandera[idx] next cycle if revelada[idx]=0; otherwise no effect;
  - no busy, no done.
- Simultaneous reveal_req and flag_req: reveal wins; the flag is dropped.
- reveal_req in IDLE, game active: latch idx = fila*8+columna and go to CHECK. Inputs are sampled only in IDLE.
- CHECK (1 cycle):
  - revealed or flagged cell → FINISH, no change;
  - bomb → set revelada for every bomb cell, perdio=1, → FINISH;
  - otherwise set revelada[idx], reveladas_cnt+1; if count==0, push idx and → POP, else → FINISH.
- POP (1 cycle):
  - stack empty → FINISH;
  - else pop to cur, dir=0 → EXPAND.
- EXPAND (8 cycles, dir 0..7: NW, N, NE, W, E, SW, S, SE):
  - consider neighbour only if in bounds (no wrap-around at row/column edges), not revealed, not flagged, not bomb;
  - for such a neighbour: set revelada, cnt+1, push if its count==0;
  - after dir 7 → POP.
- Each cell is marked revealed when pushed, so it is pushed at most once and the stack cannot overflow at depth 64.
- Push and pop never occur in the same cycle.
- FINISH (1 cycle):
  - done=1;
  - gano=1 if perdio=0 and reveladas_cnt == 64 − bomb total (evaluated using the updated count);
  - → IDLE.
- Latency:
  - plain reveal: request accepted at edge k, done high in cycle k+2;
  - flood: 2 + 9·Z + 1 cycles after acceptance, where Z = zero cells popped.
- Flags are never cleared by flood-fill; a flagged zero cell blocks propagation.
- Count width: reveladas_cnt saturates naturally at 64 and fits in 7 bits.

Decomposition:
- Package buscaminas_pkg:
  - N and cell-index width;
  - cell bit positions BOMBA_BIT=8, CUENTA_MSB=3;
  - typedef celda_t (9 bits);
  - state enum {IDLE, CHECK, POP, EXPAND, FINISH};
  - direction row/column offset constants.
- Sub-module pila_indices: synchronous LIFO, PILA_DEPTH x 6 bits, with push, pop, empty and count; asynchronous active-high reset clears the pointer.

Test Plan:
- Reveal on a bomb: bomb at (2,3), reveal at (2,3) → perdio=1, revelada set only at bomb cells, done 2 cycles after acceptance.
- Reveal on a numbered cell: board with one bomb at (0,0), reveal (0,1) whose count is 1 → revelada bit 1 only, reveladas_cnt=1, done at k+2.
- Flood fill to win: same board, reveal (7,7) → all 63 non-bomb cells revealed, reveladas_cnt=63, gano=1, (0,0) still unrevealed; busy length matches the latency formula.
- Flag blocking: flag (4,4) in an all-zero region, then reveal (7,7) → bandera[36]=1, revelada[36]=0, gano=0; reveal (4,4) → no change.
- Edge wrap: bomb at (0,7), reveal (1,0) → no cell in column 7 is revealed via wrap from column 0 neighbours.
- Reset and restart: assert reset mid-flood → all outputs 0 next edge, busy=0; then start_game → bomb total re-latched, subsequent reveal works.

Source files
------------

// File: rtl/buscaminas_pkg.sv
// Shared types and constants for the Minesweeper player-side logic.
// Board geometry, cell layout, FSM states and neighbour offsets.
package buscaminas_pkg;

    localparam int N          = 8;
    localparam int CELDAS     = N * N;
    localparam int IDX_W      = 6;
    localparam int BOMBA_BIT  = 8;
    localparam int CUENTA_MSB = 3;

    typedef logic [8:0] celda_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        POP,
        EXPAND,
        FINISH
    } estado_t;

    // Offsets are 2-bit two's complement: 11=-1, 00=0, 01=+1.
    // Direction order: NW, N, NE, W, E, SW, S, SE.
    function automatic logic [1:0] dir_df(input logic [2:0] d);
        unique case (d)
            3'd0, 3'd1, 3'd2: dir_df = 2'b11;
            3'd3, 3'd4:       dir_df = 2'b00;
            default:          dir_df = 2'b01;
        endcase
    endfunction

    function automatic logic [1:0] dir_dc(input logic [2:0] d);
        unique case (d)
            3'd0, 3'd3, 3'd5: dir_dc = 2'b11;
            3'd1, 3'd6:       dir_dc = 2'b00;
            default:          dir_dc = 2'b01;
        endcase
    endfunction

    function automatic logic es_cero(input celda_t c);
        es_cero = (c[CUENTA_MSB:0] == 4'd0);
    endfunction

endpackage

// File: rtl/revelar_casillas_if.sv
// Command/status bundle between the player controls and the reveal engine.
// master drives commands and reads masks; slave is the engine.
interface revelar_casillas_if;
    import buscaminas_pkg::*;

    logic              start_game;
    logic              reveal_req;
    logic              flag_req;
    logic [2:0]        fila;
    logic [2:0]        columna;
    logic              busy;
    logic              done;
    logic [CELDAS-1:0] revelada;
    logic [CELDAS-1:0] bandera;
    logic              perdio;
    logic              gano;
    logic [6:0]        reveladas_cnt;

    modport master (
        output start_game, reveal_req, flag_req, fila, columna,
        input  busy, done, revelada, bandera, perdio, gano,
        input  reveladas_cnt
    );

    modport slave (
        input  start_game, reveal_req, flag_req, fila, columna,
        output busy, done, revelada, bandera, perdio, gano,
        output reveladas_cnt
    );

endinterface

// File: rtl/revelar_casillas_pila.sv
// LIFO of cell indices used by the flood-fill.
// dout always shows the top entry; pop only moves the pointer.
module pila_indices
    import buscaminas_pkg::*;
#(
    parameter int PILA_DEPTH = 64
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic                              pop,
    input  logic [IDX_W-1:0]                  din,
    output logic [IDX_W-1:0]                  dout,
    output logic                              empty,
    output logic [$clog2(PILA_DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(PILA_DEPTH + 1);
    localparam int AW = $clog2(PILA_DEPTH);

    logic [IDX_W-1:0] mem [PILA_DEPTH];
    logic [PW-1:0]    ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
        end else if (pop && ptr != '0) begin
            ptr <= ptr - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[AW'(ptr)] <= din;
        end
    end

    assign dout  = mem[AW'(ptr - PW'(1))];
    assign empty = (ptr == '0);
    assign count = ptr;

endmodule

// File: rtl/revelar_casillas.sv
// Reveal/flag engine over a finished 8x8 Minesweeper board.
// Flood-fills zero regions with an index stack; tracks win/loss.
module revelar_casillas
    import buscaminas_pkg::*;
#(
    parameter int PILA_DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  celda_t [N-1:0][N-1:0]      matrizEntrada,
    revelar_casillas_if.slave          bus
);

    localparam int PW = $clog2(PILA_DEPTH + 1);

    estado_t           estado, sig;
    logic [IDX_W-1:0]  idx, cur, nb_idx, fidx, push_d, pila_q;
    logic [2:0]        dir;
    logic [CELDAS-1:0] revelada, bandera, bombas;
    logic [6:0]        cnt, total_bombas, bomb_pop;
    logic              perdio, gano, activo;
    logic              push_w, push, pop, pila_vacia;
    logic [PW-1:0]     pila_cnt;
    logic [1:0]        df, dc;
    logic [3:0]        nb_f, nb_c;
    logic              nb_ok;
    celda_t            c_idx, c_nb;

    assign activo = !perdio && !gano;
    assign fidx   = {bus.fila, bus.columna};
    assign c_idx  = matrizEntrada[idx[5:3]][idx[2:0]];

    always_comb begin
        bombas   = '0;
        bomb_pop = '0;
        for (int i = 0; i < CELDAS; i++) begin
            bombas[6'(i)] = matrizEntrada[3'(i / N)][3'(i % N)][BOMBA_BIT];
            bomb_pop      = bomb_pop + 7'(bombas[6'(i)]);
        end
    end

    // Out-of-range rows/columns (-1 or 8) both land with bit 3 set.
    assign df     = dir_df(dir);
    assign dc     = dir_dc(dir);
    assign nb_f   = {1'b0, cur[5:3]} + {{2{df[1]}}, df};
    assign nb_c   = {1'b0, cur[2:0]} + {{2{dc[1]}}, dc};
    assign nb_idx = {nb_f[2:0], nb_c[2:0]};
    assign c_nb   = matrizEntrada[nb_f[2:0]][nb_c[2:0]];
    assign nb_ok  = !nb_f[3] && !nb_c[3] && !revelada[nb_idx]
                    && !bandera[nb_idx] && !c_nb[BOMBA_BIT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= IDLE;
        else       estado <= sig;
    end

    always_comb begin
        sig    = estado;
        push_w = 1'b0;
        pop    = 1'b0;
        push_d = idx;
        unique case (estado)
            IDLE: begin
                if (!bus.start_game && bus.reveal_req && activo)
                    sig = CHECK;
            end
            CHECK: begin
                if (revelada[idx] || bandera[idx] || c_idx[BOMBA_BIT]) begin
                    sig = FINISH;
                end else if (es_cero(c_idx)) begin
                    push_w = 1'b1;
                    sig    = POP;
                end else begin
                    sig = FINISH;
                end
            end
            POP: begin
                if (pila_vacia) begin
                    sig = FINISH;
                end else begin
                    pop = 1'b1;
                    sig = EXPAND;
                end
            end
            EXPAND: begin
                if (nb_ok && es_cero(c_nb)) begin
                    push_w = 1'b1;
                    push_d = nb_idx;
                end
                if (dir == 3'd7) sig = POP;
            end
            FINISH:  sig = IDLE;
            default: sig = IDLE;
        endcase
    end

    assign push = push_w && (pila_cnt != PW'(PILA_DEPTH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            revelada     <= '0;
            bandera      <= '0;
            perdio       <= 1'b0;
            gano         <= 1'b0;
            cnt          <= '0;
            total_bombas <= '0;
            idx          <= '0;
            cur          <= '0;
            dir          <= '0;
        end else begin
            unique case (estado)
                IDLE: begin
                    if (bus.start_game) begin
                        revelada     <= '0;
                        bandera      <= '0;
                        perdio       <= 1'b0;
                        gano         <= 1'b0;
                        cnt          <= '0;
                        total_bombas <= bomb_pop;
                    end else if (bus.reveal_req && activo) begin
                        idx <= fidx;
                    end else if (bus.flag_req && activo && !revelada[fidx]) begin
                        bandera[fidx] <= !bandera[fidx];
                    end
                end
                CHECK: begin
                    if (!revelada[idx] && !bandera[idx]) begin
                        if (c_idx[BOMBA_BIT]) begin
                            revelada <= revelada | bombas;
                            perdio   <= 1'b1;
                        end else begin
                            revelada[idx] <= 1'b1;
                            cnt           <= cnt + 7'd1;
                        end
                    end
                end
                POP: begin
                    if (!pila_vacia) begin
                        cur <= pila_q;
                        dir <= '0;
                    end
                end
                EXPAND: begin
                    if (nb_ok) begin
                        revelada[nb_idx] <= 1'b1;
                        cnt              <= cnt + 7'd1;
                    end
                    dir <= dir + 3'd1;
                end
                FINISH: begin
                    if (!perdio && cnt == 7'(CELDAS) - total_bombas)
                        gano <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    pila_indices #(
        .PILA_DEPTH (PILA_DEPTH)
    ) u_pila (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_d),
        .dout  (pila_q),
        .empty (pila_vacia),
        .count (pila_cnt)
    );

    assign bus.busy          = (estado != IDLE);
    assign bus.done          = (estado == FINISH);
    assign bus.revelada      = revelada;
    assign bus.bandera       = bandera;
    assign bus.perdio        = perdio;
    assign bus.gano          = gano;
    assign bus.reveladas_cnt = cnt;

endmodule

// File: tb/tb_revelar_casillas.sv
// Bench for revelar_casillas: directed games against a BFS board model,
// with a per-cycle idle compare and hand-computed latency/count pins.
module tb_revelar_casillas;
    import buscaminas_pkg::*;

    logic clk = 1'b0;
    logic reset;
    celda_t [N-1:0][N-1:0] mat;

    always #5 clk = ~clk;

    revelar_casillas_if bus ();

    revelar_casillas dut (
        .clk           (clk),
        .reset         (reset),
        .matrizEntrada (mat),
        .bus           (bus)
    );

    int          tests = 0;
    int          fails = 0;
    bit          chk   = 1'b0;
    logic [63:0] bombs, m_rev, m_flag;
    int          m_cnt, m_btot, mlat;
    bit          m_perdio, m_gano;

    task automatic chk_eq(input string nm, input logic [63:0] act,
                          input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            chk_eq("idle_busy", bus.busy, 0);
            chk_eq("idle_done", bus.done, 0);
            chk_eq("revelada", bus.revelada, m_rev);
            chk_eq("bandera", bus.bandera, m_flag);
            chk_eq("perdio", bus.perdio, m_perdio);
            chk_eq("gano", bus.gano, m_gano);
            chk_eq("cnt", bus.reveladas_cnt, m_cnt);
        end
    end

    task automatic build(input logic [63:0] bm);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dcc = -1; dcc <= 1; dcc++) begin
                        int rr, cc;
                        rr = r + dr;
                        cc = c + dcc;
                        if ((dr != 0 || dcc != 0) && rr >= 0 && rr < 8
                            && cc >= 0 && cc < 8 && bm[rr*8+cc])
                            n++;
                    end
                end
                mat[r][c] = {bm[r*8+c], 4'hA, 4'(n)};
            end
        end
        bombs = bm;
    endtask

    function automatic bit cero(input int j);
        cero = (mat[j/8][j%8][3:0] == 4'd0);
    endfunction

    // Board-level semantics: what the whole reveal command must produce.
    task automatic m_reveal(input int r, input int c, output int lat);
        int i, z, k, rr, cc, j;
        int q[$];
        i   = r * 8 + c;
        lat = 2;
        z   = 0;
        if (m_rev[i] || m_flag[i]) begin
        end else if (bombs[i]) begin
            m_rev    = m_rev | bombs;
            m_perdio = 1'b1;
        end else begin
            m_rev[i] = 1'b1;
            m_cnt++;
            if (cero(i)) q.push_back(i);
            while (q.size() > 0) begin
                k = q.pop_front();
                z++;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dcc = -1; dcc <= 1; dcc++) begin
                        rr = k / 8 + dr;
                        cc = k % 8 + dcc;
                        if ((dr != 0 || dcc != 0) && rr >= 0 && rr < 8
                            && cc >= 0 && cc < 8) begin
                            j = rr * 8 + cc;
                            if (!m_rev[j] && !m_flag[j] && !bombs[j]) begin
                                m_rev[j] = 1'b1;
                                m_cnt++;
                                if (cero(j)) q.push_back(j);
                            end
                        end
                    end
                end
            end
            if (z > 0) lat = 3 + 9 * z;
        end
        if (!m_perdio && m_cnt == 64 - m_btot) m_gano = 1'b1;
    endtask

    task automatic do_start(input logic [63:0] bm);
        chk = 1'b0;
        build(bm);
        bus.start_game = 1'b1;
        @(negedge clk);
        bus.start_game = 1'b0;
        m_rev    = '0;
        m_flag   = '0;
        m_cnt    = 0;
        m_perdio = 1'b0;
        m_gano   = 1'b0;
        m_btot   = $countones(bm);
        chk      = 1'b1;
    endtask

    task automatic do_flag(input int r, input int c);
        int i;
        bit act;
        i   = r * 8 + c;
        act = !m_perdio && !m_gano;
        chk = 1'b0;
        bus.fila     = 3'(r);
        bus.columna  = 3'(c);
        bus.flag_req = 1'b1;
        @(negedge clk);
        bus.flag_req = 1'b0;
        chk_eq("flag_busy", bus.busy, 0);
        if (act && !m_rev[i]) m_flag[i] = !m_flag[i];
        chk = 1'b1;
    endtask

    task automatic do_reveal(input int r, input int c, input bit fl,
                             input bit poke, output int lat);
        int n;
        bit act;
        act = !m_perdio && !m_gano;
        lat = 0;
        chk = 1'b0;
        bus.fila       = 3'(r);
        bus.columna    = 3'(c);
        bus.reveal_req = 1'b1;
        bus.flag_req   = fl;
        @(negedge clk);
        bus.reveal_req = 1'b0;
        bus.flag_req   = 1'b0;
        if (!act) begin
            chk_eq("ignored_busy", bus.busy, 0);
            chk = 1'b1;
            return;
        end
        m_reveal(r, c, lat);
        chk_eq("busy_check", bus.busy, 1);
        n = 1;
        while (!bus.done && n < 1000) begin
            bus.start_game = poke && (n == 5);
            @(negedge clk);
            n++;
        end
        bus.start_game = 1'b0;
        if (!bus.done) chk_eq("done_timeout", 0, 1);
        chk_eq("latency", n, lat);
        @(negedge clk);
        chk = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        bus.start_game = 1'b0;
        bus.reveal_req = 1'b0;
        bus.flag_req   = 1'b0;
        bus.fila       = '0;
        bus.columna    = '0;
        m_rev = '0; m_flag = '0; m_cnt = 0; m_btot = 0;
        m_perdio = 1'b0; m_gano = 1'b0;
        build(64'h0);
        repeat (2) @(negedge clk);
        chk_eq("rst_busy", bus.busy, 0);
        chk_eq("rst_rev", bus.revelada, 0);
        chk_eq("rst_cnt", bus.reveladas_cnt, 0);
        reset = 1'b0;
        chk   = 1'b1;

        // bomb hit at (2,3); afterwards the game is over
        do_start(64'h1 << 19);
        do_reveal(2, 3, 0, 0, mlat);
        chk_eq("bomb_lat_lit", mlat, 2);
        chk_eq("bomb_rev_lit", bus.revelada, 64'h1 << 19);
        chk_eq("bomb_perdio_lit", bus.perdio, 1);
        do_flag(0, 0);
        do_reveal(0, 0, 0, 0, mlat);

        // single bomb at (0,0)
        do_start(64'h1);
        do_reveal(0, 1, 0, 0, mlat);
        chk_eq("num_rev_lit", bus.revelada, 64'h2);
        chk_eq("num_cnt_lit", bus.reveladas_cnt, 1);
        do_reveal(1, 1, 1, 0, mlat);
        chk_eq("rev_wins_flag", bus.bandera, 0);
        do_reveal(7, 7, 0, 0, mlat);
        chk_eq("flood_lat_lit", mlat, 543);
        chk_eq("flood_cnt_lit", m_cnt, 63);
        chk_eq("flood_rev_lit", bus.revelada, ~64'h1);
        chk_eq("flood_gano_lit", bus.gano, 1);

        // flagged zero cell blocks the flood; start mid-flood is ignored
        do_start(64'h0);
        do_flag(4, 4);
        do_reveal(7, 7, 0, 1, mlat);
        chk_eq("blk_lat_lit", mlat, 570);
        chk_eq("blk_rev_lit", bus.revelada, ~(64'h1 << 36));
        chk_eq("blk_gano_lit", bus.gano, 0);
        do_flag(0, 0);
        do_reveal(4, 4, 0, 0, mlat);
        chk_eq("flagged_lat_lit", mlat, 2);
        do_flag(4, 4);
        do_reveal(4, 4, 0, 0, mlat);
        chk_eq("last_lat_lit", mlat, 12);
        chk_eq("last_gano_lit", m_gano, 1);

        // column 6 all bombs: no wrap from column 0 into column 7
        do_start(64'h4040404040404040);
        do_reveal(1, 0, 0, 0, mlat);
        chk_eq("wrap_col7_lit", bus.revelada & 64'h8080808080808080, 0);
        chk_eq("wrap_cnt_lit", bus.reveladas_cnt, 48);
        chk_eq("wrap_lat_lit", mlat, 363);
        do_start(64'h1 << 7);
        do_reveal(1, 0, 0, 0, mlat);
        chk_eq("edge_cnt_lit", m_cnt, 63);

        // reset in the middle of a flood, then restart
        do_start(64'h1);
        chk = 1'b0;
        bus.fila       = 3'd7;
        bus.columna    = 3'd7;
        bus.reveal_req = 1'b1;
        @(negedge clk);
        bus.reveal_req = 1'b0;
        repeat (50) @(negedge clk);
        chk_eq("pre_rst_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        chk_eq("mid_rst_busy", bus.busy, 0);
        chk_eq("mid_rst_rev", bus.revelada, 0);
        chk_eq("mid_rst_cnt", bus.reveladas_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        m_rev = '0; m_flag = '0; m_cnt = 0; m_btot = 0;
        m_perdio = 1'b0; m_gano = 1'b0;
        chk = 1'b1;
        @(negedge clk);
        do_start(64'h1);
        do_reveal(0, 1, 0, 0, mlat);
        do_reveal(7, 7, 0, 0, mlat);
        chk_eq("restart_gano_lit", bus.gano, 1);

        repeat (2) @(negedge clk);
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
